// File: rtl/mem_sched_pkg.sv
// Shared types and default timing constants for the SDRAM slot scheduler.
//   state_t : scheduler mode (LOAD while the NES is held in reset, RUN otherwise)
//   cmd_t   : command class selected for the next memory slot
package mem_sched_pkg;

  // Default NES cycle shape: 7 clk per NES cycle, memory slot in phase 0,
  // clock enable in phase 6 so a read issued in phase 0 (latency 4) has
  // returned before the NES consumes it.
  localparam int unsigned DEF_PHASES     = 7;
  localparam int unsigned DEF_MEM_PHASE  = 0;
  localparam int unsigned DEF_NES_PHASE  = 6;
  localparam int unsigned DEF_ADDR_W     = 22;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_READ,
    CMD_WRITE,
    CMD_REFRESH
  } cmd_t;

endpackage

// File: rtl/ldr_wr_fifo.sv
// Small synchronous FIFO buffering loader writes until a free memory slot.
//   clk, resetn : clock, asynchronous active-low reset (clears pointers/count)
//   push, din   : write strobe and entry; accepted when not full, or when
//                 full and a pop happens in the same cycle
//   pop, dout   : read strobe and head entry (dout valid while !empty)
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module ldr_wr_fifo #(
  parameter int unsigned DEPTH = 4,   // power of two, at least 2
  parameter int unsigned WIDTH = 30,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr];

  // NOTE: storage is not reset; only the pointers and count define which
  // entries are valid, and leaving the array reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_slot_sched.sv
// Shares the single SDRAM controller port between the NES core and the game
// loader, and generates the NES clock-enable schedule.
//   clk, resetn                     : clock, asynchronous active-low reset
//   reset_nes                       : 1 = loader mode (NES held in reset)
//   nes_read_cpu/ppu, nes_write     : NES access requests, nes_addr/nes_dout
//   ldr_write, ldr_addr, ldr_data   : loader byte write (buffered in a FIFO)
//   ldr_refresh                     : loader refresh request pulse
//   mem_busy                        : controller busy (honoured in LOAD only)
//   run_nes, phase                  : NES clock enable and current phase
//   mem_read_a/b, mem_write,
//   mem_refresh, mem_addr, mem_din  : registered command port to controller
//   ldr_full, overflow              : FIFO full, sticky dropped-write flag
module mem_slot_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned PHASES     = DEF_PHASES,
  parameter int unsigned MEM_PHASE  = DEF_MEM_PHASE,
  parameter int unsigned NES_PHASE  = DEF_NES_PHASE,  // >= MEM_PHASE + 5
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              reset_nes,
  input  logic              nes_read_cpu,
  input  logic              nes_read_ppu,
  input  logic              nes_write,
  input  logic [ADDR_W-1:0] nes_addr,
  input  logic [7:0]        nes_dout,
  input  logic              ldr_write,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_data,
  input  logic              ldr_refresh,
  input  logic              mem_busy,
  output logic              run_nes,
  output logic [3:0]        phase,
  output logic              mem_read_a,
  output logic              mem_read_b,
  output logic              mem_write,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              ldr_full,
  output logic              overflow
);

  localparam int unsigned   FIFO_W     = ADDR_W + 8;
  localparam int unsigned   CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0]    LAST_PHASE = 4'(PHASES - 1);
  localparam logic [3:0]    MEM_PH     = 4'(MEM_PHASE);
  localparam logic [3:0]    NES_PH     = 4'(NES_PHASE);

  state_t            state;
  state_t            next_state;
  logic [3:0]        next_phase;

  cmd_t              cmd;
  logic              cmd_rd_a;
  logic              cmd_rd_b;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;
  logic              cmd_issued;
  logic              refresh_pend;

  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  ldr_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (ldr_write),
    .din    ({ldr_addr, ldr_data}),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign ldr_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign cmd_issued = mem_read_a | mem_read_b | mem_write | mem_refresh;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_LOAD;
      phase <= '0;
    end else begin
      state <= next_state;
      phase <= next_phase;
    end
  end

  // The phase counter restarts at 0 on entry to RUN and is parked at 0 in LOAD.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = S_LOAD;
    next_phase = '0;
    if (!reset_nes) begin
      next_state = S_RUN;
      if (state == S_RUN) begin
        next_phase = (phase == LAST_PHASE) ? '0 : phase + 4'd1;
      end
    end
  end

  // ------------------------------------------------------ command select
  // The command is chosen for the cycle being entered, so strobes line up
  // with the registered phase output they belong to.
  always_comb begin
    cmd      = CMD_NONE;
    cmd_rd_a = 1'b0;
    cmd_rd_b = 1'b0;
    cmd_addr = nes_addr;
    cmd_data = nes_dout;
    fifo_pop = 1'b0;
    if (next_state == S_RUN) begin
      if (next_phase == MEM_PH) begin
        if (nes_write) begin
          cmd = CMD_WRITE;
        end else if (nes_read_cpu || nes_read_ppu) begin
          cmd      = CMD_READ;
          cmd_rd_a = nes_read_cpu;
          cmd_rd_b = nes_read_ppu;
        end else if (!fifo_empty) begin
          cmd      = CMD_WRITE;
          fifo_pop = 1'b1;
          cmd_addr = fifo_dout[FIFO_W-1:8];
          cmd_data = fifo_dout[7:0];
        end else begin
          cmd = CMD_REFRESH;
        end
      end
    end else if (state == S_LOAD && !mem_busy && !cmd_issued) begin
      // Requiring state==LOAD keeps the first cycle after RUN->LOAD quiet;
      // !cmd_issued spaces loader commands at least one idle cycle apart.
      if (!fifo_empty) begin
        cmd      = CMD_WRITE;
        fifo_pop = 1'b1;
        cmd_addr = fifo_dout[FIFO_W-1:8];
        cmd_data = fifo_dout[7:0];
      end else if (refresh_pend) begin
        cmd = CMD_REFRESH;
      end
    end
  end

  // ------------------------------------------------------ output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_nes      <= 1'b0;
      mem_read_a   <= 1'b0;
      mem_read_b   <= 1'b0;
      mem_write    <= 1'b0;
      mem_refresh  <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      overflow     <= 1'b0;
      refresh_pend <= 1'b0;
    end else begin
      run_nes     <= (next_state == S_RUN) && (next_phase == NES_PH);
      mem_read_a  <= (cmd == CMD_READ) && cmd_rd_a;
      mem_read_b  <= (cmd == CMD_READ) && cmd_rd_b;
      mem_write   <= (cmd == CMD_WRITE);
      mem_refresh <= (cmd == CMD_REFRESH);
      // Address/data hold across refresh and idle cycles.
      if (cmd == CMD_WRITE) begin
        mem_addr <= cmd_addr;
        mem_din  <= cmd_data;
      end else if (cmd == CMD_READ) begin
        mem_addr <= cmd_addr;
      end
      // A new request in the issuing cycle keeps the flag set.
      refresh_pend <= ldr_refresh | (refresh_pend & (cmd != CMD_REFRESH));
      if (ldr_write && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
